// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and defaults for alu_mdu
//
// Purpose: opcode constants (ALU_ADD..ALU_MFLO), multiply/divide FSM state
// encoding and the default opcode width used by alu_mdu and its submodules.
package alu_pkg;

  localparam int ALU_SEL_WIDTH = 5;

  // Opcodes are kept as 32-bit constants; the top zero-extends op_sel to
  // 32 bits before decoding so SEL_WIDTH can change without touching these.
  localparam int unsigned ALU_ADD   = 32'd0;
  localparam int unsigned ALU_SUB   = 32'd1;
  localparam int unsigned ALU_AND   = 32'd2;
  localparam int unsigned ALU_OR    = 32'd3;
  localparam int unsigned ALU_SLT   = 32'd4;
  localparam int unsigned ALU_SGT   = 32'd5;
  localparam int unsigned ALU_NOR   = 32'd6;
  localparam int unsigned ALU_XOR   = 32'd7;
  localparam int unsigned ALU_SLL   = 32'd8;
  localparam int unsigned ALU_SRL   = 32'd9;
  localparam int unsigned ALU_SRA   = 32'd10;
  localparam int unsigned ALU_SLTU  = 32'd11;
  localparam int unsigned ALU_MULT  = 32'd12;
  localparam int unsigned ALU_MULTU = 32'd13;
  localparam int unsigned ALU_DIV   = 32'd14;
  localparam int unsigned ALU_DIVU  = 32'd15;
  localparam int unsigned ALU_MFHI  = 32'd16;
  localparam int unsigned ALU_MFLO  = 32'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative unsigned shift-add multiply / restoring divide
//
// Purpose: one radix-2 step per cycle on unsigned magnitudes; sign handling
// is left to the caller.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture a/b and clear accumulator and counter
//   step          perform one iteration
//   is_div        1 = restoring divide step, 0 = shift-add multiply step
//   a, b          multiplicand/multiplier or dividend/divisor magnitudes
//   acc           multiply: product high half; divide: remainder
//   mq            multiply: product low half;  divide: quotient
//   last          the current step is the final (DATA_WIDTH-th) one
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] mq,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] opb;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   shifted;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_rem;

  assign last = (cnt == DATA_WIDTH'(DATA_WIDTH - 1));

  // Multiply: {acc,mq} shifts right one bit per step, adding the
  // multiplicand into the upper half when the multiplier LSB is set.
  assign addend  = mq[0] ? opb : '0;
  assign mul_sum = {1'b0, acc} + {1'b0, addend};

  // Divide: the remainder never reaches the divisor, so after subtracting
  // the true difference always fits in DATA_WIDTH bits.
  assign shifted = {acc, mq[DATA_WIDTH-1]};
  assign div_ge  = (shifted >= {1'b0, opb});
  assign div_rem = div_ge ? (shifted[DATA_WIDTH-1:0] - opb) : shifted[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mq  <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      mq  <= a;
      opb <= b;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + DATA_WIDTH'(1);
      if (is_div) begin
        acc <= div_rem;
        mq  <= {mq[DATA_WIDTH-2:0], div_ge};
      end else begin
        acc <= mul_sum[DATA_WIDTH:1];
        mq  <= {mul_sum[0], mq[DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EX-stage ALU with registered result and iterative MDU
//
// Purpose: single-cycle ALU ops registered into result/overflow/zero, plus
// multi-cycle multiply/divide writing HI/LO; busy stalls the pipeline.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, flush        request valid, abort in-flight multi-cycle op
//   op_sel              opcode (see alu_pkg)
//   operand1/operand2   A (rs) / B (rt)
//   shamt               shift amount applied to operand2
//   result, overflow,   registered result and flags
//   zero, out_valid     out_valid pulses one cycle per completed op
//   busy                multi-cycle op in progress
//   hi, lo              HI/LO registers
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = ALU_SEL_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic [SEL_WIDTH-1:0]   op_sel,
  input  logic [DATA_WIDTH-1:0]  operand1,
  input  logic [DATA_WIDTH-1:0]  operand2,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   overflow,
  output logic                   zero,
  output logic                   out_valid,
  output logic                   busy,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo
);

  localparam int W = DATA_WIDTH;

  mdu_state_t state, state_nx;

  logic [31:0]    opc;
  logic           accept;
  logic           is_mul;
  logic           is_divop;
  logic           op_signed;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           load;
  logic           step;
  logic           last;
  logic [W-1:0]   iter_acc;
  logic [W-1:0]   iter_mq;

  // Captured at accept for the sign fix-up and divide-by-zero case at DONE.
  logic           div_op;
  logic           neg_main;
  logic           neg_rem;
  logic           div_zero;
  logic [W-1:0]   a_keep;

  logic [W-1:0]   sum;
  logic [W-1:0]   diff;
  logic [W-1:0]   alu_res;
  logic           alu_ovf;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   fin_hi;
  logic [W-1:0]   fin_lo;

  assign opc       = 32'(op_sel);
  assign is_mul    = (opc == ALU_MULT) || (opc == ALU_MULTU);
  assign is_divop  = (opc == ALU_DIV)  || (opc == ALU_DIVU);
  assign op_signed = (opc == ALU_MULT) || (opc == ALU_DIV);
  assign a_neg     = op_signed & operand1[W-1];
  assign b_neg     = op_signed & operand2[W-1];
  assign a_mag     = a_neg ? -operand1 : operand1;
  assign b_mag     = b_neg ? -operand2 : operand2;

  // flush wins over start, and nothing is accepted outside IDLE.
  assign accept = start && !flush && (state == ST_IDLE);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul)        state_nx = ST_MUL;
        else if (accept && is_divop) state_nx = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (flush)     state_nx = ST_IDLE;
        else if (last) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state != ST_IDLE);
    load = accept && (is_mul || is_divop);
    step = ((state == ST_MUL) || (state == ST_DIV)) && !flush;
  end

  mdu_iter #(.DATA_WIDTH(W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (state == ST_DIV),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (iter_acc),
    .mq     (iter_mq),
    .last   (last)
  );

  // ---- single-cycle datapath ----
  assign sum  = operand1 + operand2;
  assign diff = operand1 - operand2;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opc)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (operand1[W-1] == operand2[W-1]) && (sum[W-1] != operand1[W-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (operand1[W-1] != operand2[W-1]) && (diff[W-1] != operand1[W-1]);
      end
      ALU_AND:  alu_res = operand1 & operand2;
      ALU_OR:   alu_res = operand1 | operand2;
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      ALU_SGT:  alu_res = {{(W-1){1'b0}}, ($signed(operand1) > $signed(operand2))};
      ALU_NOR:  alu_res = ~(operand1 | operand2);
      ALU_XOR:  alu_res = operand1 ^ operand2;
      ALU_SLL:  alu_res = operand2 << shamt;
      ALU_SRL:  alu_res = operand2 >> shamt;
      ALU_SRA:  alu_res = $signed(operand2) >>> shamt;
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (operand1 < operand2)};
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  // ---- multi-cycle completion: sign fix-up of the magnitude results ----
  assign prod_s = neg_main ? -{iter_acc, iter_mq} : {iter_acc, iter_mq};

  always_comb begin
    fin_hi = prod_s[2*W-1:W];
    fin_lo = prod_s[W-1:0];
    if (div_op) begin
      if (div_zero) begin
        fin_hi = a_keep;
        fin_lo = '1;
      end else begin
        fin_hi = neg_rem  ? -iter_acc : iter_acc;
        fin_lo = neg_main ? -iter_mq  : iter_mq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_op   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_keep   <= '0;
    end else if (load) begin
      div_op   <= is_divop;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (operand2 == '0);
      a_keep   <= operand1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul && !is_divop) begin
        result    <= alu_res;
        overflow  <= alu_ovf;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if ((state == ST_DONE) && !flush) begin
        hi        <= fin_hi;
        lo        <= fin_lo;
        result    <= fin_lo;
        overflow  <= 1'b0;
        zero      <= (fin_lo == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [4:0]  op_sel;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        out_valid;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  alu_mdu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op_sel    (op_sel),
    .operand1  (operand1),
    .operand2  (operand2),
    .shamt     (shamt),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    op_sel   = op[4:0];
    operand1 = a;
    operand2 = b;
    shamt    = sh;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic single(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_ovf);
    issue(op, a, b, sh);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".ovf"}, overflow, exp_ovf);
    check({tag, ".zero"}, zero, exp_res == 0);
  endtask

  // Multi-cycle op; optionally pokes an ADD start while busy.
  task automatic mdu(input string tag, input int op, input logic [31:0] a,
                     input logic [31:0] b, input bit poke,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(op, a, b, 0);
    check({tag, ".busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (poke && lat == 5) begin
        op_sel = 5'd0; operand1 = 32'd1; operand2 = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, 33);
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
    check({tag, ".result"}, result, exp_lo);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt_v;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op_sel = '0; operand1 = '0; operand2 = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.result", result, 0);
    check("rst.ovf", overflow, 0);
    check("rst.zero", zero, 1);
    check("rst.valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    single("add_ovf", 0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 1);
    @(posedge clk); #1;
    check("hold.valid", out_valid, 0);
    check("hold.result", result, 32'h8000_0000);
    single("add_negovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h7FFF_FFFF, 1);
    single("sub_zero", 1, 32'd5, 32'd5, 0, 32'h0, 0);
    single("sub_ovf", 1, 32'h8000_0000, 32'd1, 0, 32'h7FFF_FFFF, 1);
    single("and", 2, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 0);
    single("nor", 6, 32'hF0F0_0000, 32'h0000_0F0F, 0, 32'h0F0F_F0F0, 0);
    single("sra", 10, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0);
    single("srl", 9, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 0);
    single("sll", 8, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 0);
    single("sltu", 11, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 0);
    single("slt", 4, 32'hFFFF_FFFF, 32'd1, 0, 32'h1, 0);
    single("sgt", 5, 32'd5, 32'hFFFF_FFFE, 0, 32'h1, 0);
    single("undef", 20, 32'h7FFF_FFFF, 32'd1, 0, 32'h0, 0);

    mdu("mult", 12, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    single("mflo", 17, 0, 0, 0, 32'hFFFF_FFF1, 0);
    single("mfhi", 16, 0, 0, 0, 32'hFFFF_FFFF, 0);
    mdu("div", 14, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    mdu("divu0", 15, 32'd9, 32'd0, 0, 32'd9, 32'hFFFF_FFFF);
    mdu("divmin", 14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000);
    mdu("multu", 13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);

    // Flush at cycle 10 of a MULTU
    issue(13, 32'h10, 32'h10, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.busy", busy, 0);
    cnt_v = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt_v++;
      @(posedge clk); #1;
    end
    check("flush.no_valid", cnt_v, 0);
    check("flush.hi", hi, 32'hFFFF_FFFE);
    check("flush.lo", lo, 32'h0000_0001);

    // flush and start together while idle
    op_sel = 5'd0; operand1 = 32'd7; operand2 = 32'd7;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flushstart.valid", out_valid, 0);
    check("flushstart.result", result, 32'h0000_0001);

    // reset in the middle of a divide
    issue(14, 32'd100, 32'd3, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.result", result, 0);
    check("midrst.zero", zero, 1);
    check("midrst.busy", busy, 0);
    check("midrst.hi", hi, 0);
    check("midrst.lo", lo, 0);
    single("add_after_rst", 0, 32'd2, 32'd3, 0, 32'd5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
